// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram_fifo
// Purpose  : Valid/ready stream FIFO over an external dual-port block RAM,
//            with a 3-entry show-ahead output buffer hiding read latency.
// Revision : 1.0 - initial release
// ============================================================================
module bram_fifo #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [DBITS-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DBITS-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ABITS+1:0]   level,
  output logic               ram_we,
  output logic [ABITS-1:0]   ram_waddr,
  output logic [DBITS-1:0]   ram_wdata,
  output logic [ABITS-1:0]   ram_raddr,
  input  logic [DBITS-1:0]   ram_rdata
);

  localparam logic [ABITS:0] c_DEPTH   = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] c_PTR_ONE = {{ABITS{1'b0}}, 1'b1};

  logic [ABITS:0]   r_wptr;
  logic [ABITS:0]   r_rptr;
  logic             r_inflight;
  logic [1:0]       r_occ;
  logic [DBITS-1:0] r_obuf0;
  logic [DBITS-1:0] r_obuf1;
  logic [DBITS-1:0] r_obuf2;

  logic [ABITS:0]   w_ram_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_pop;
  logic             w_issue;
  logic [1:0]       w_occ_nxt;
  logic [1:0]       w_tail;
  logic [DBITS-1:0] w_ob0;
  logic [DBITS-1:0] w_ob1;
  logic [DBITS-1:0] w_ob2;

  assign w_ram_cnt = r_wptr - r_rptr;
  assign w_full    = (w_ram_cnt == c_DEPTH);
  assign w_empty   = (w_ram_cnt == '0);

  // Write side: the RAM port is a direct function of the handshake.
  assign s_ready   = !rst && !clr && !w_full;
  assign w_wr      = s_valid && s_ready;
  assign ram_we    = w_wr;
  assign ram_waddr = r_wptr[ABITS-1:0];
  assign ram_wdata = s_data;

  // Reads are issued from registered state only, so m_ready never reaches
  // the RAM address path; occ+inflight<3 guarantees a free slot on return.
  assign w_issue   = !clr && !w_empty && (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
  assign ram_raddr = r_rptr[ABITS-1:0];

  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_obuf0;
  assign w_pop     = m_valid && m_ready;

  assign w_occ_nxt = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_tail    = r_occ - {1'b0, w_pop};

  assign level = {1'b0, w_ram_cnt}
               + {{(ABITS+1){1'b0}}, r_inflight}
               + {{ABITS{1'b0}}, r_occ};

  always_comb begin
    w_ob0 = r_obuf0;
    w_ob1 = r_obuf1;
    w_ob2 = r_obuf2;
    if (w_pop) begin
      w_ob0 = r_obuf1;
      w_ob1 = r_obuf2;
    end
    if (r_inflight) begin
      case (w_tail)
        2'd0:    w_ob0 = ram_rdata;
        2'd1:    w_ob1 = ram_rdata;
        default: w_ob2 = ram_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + c_PTR_ONE;
      if (w_issue)
        r_rptr <= r_rptr + c_PTR_ONE;
      r_inflight <= w_issue;
      r_occ      <= w_occ_nxt;
    end
  end

  // Payload registers carry no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    r_obuf0 <= w_ob0;
    r_obuf1 <= w_ob1;
    r_obuf2 <= w_ob2;
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_fifo
// Purpose  : Self-checking bench for bram_fifo with a behavioural RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_fifo;

  localparam int ABITS = 4;
  localparam int DBITS = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [DBITS-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [DBITS-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [ABITS+1:0] level;
  logic             ram_we;
  logic [ABITS-1:0] ram_waddr;
  logic [DBITS-1:0] ram_wdata;
  logic [ABITS-1:0] ram_raddr;
  logic [DBITS-1:0] ram_rdata;

  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  logic [DBITS-1:0] sb [$];
  logic             hold_prev = 1'b0;
  logic [DBITS-1:0] hold_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  bram_fifo #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .ram_we   (ram_we),
    .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then advance.
  task automatic tick();
    @(negedge clk);
    if (hold_prev && !rst && !clr) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(hold_data));
    end
    hold_prev = m_valid && !m_ready && !rst && !clr;
    hold_data = m_data;
    if (s_valid && s_ready) begin
      sb.push_back(s_data);
      n_acc++;
    end
    if (m_valid && m_ready) begin
      n_pop++;
      check("sb_underflow", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("sb_data", 32'(m_data), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_waddr", 32'(ram_waddr), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_s_ready", 32'(s_ready), 32'd1);

    // Latency: write at t, visible at t+3, level clears at t+4.
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    #1;
    check("lat_we", 32'(ram_we), 32'd1);
    check("lat_waddr", 32'(ram_waddr), 32'd0);
    check("lat_wdata", 32'(ram_wdata), 32'hA5);
    tick(); s_valid = 1'b0;
    check("lat_t1_valid", 32'(m_valid), 32'd0);
    check("lat_t1_level", 32'(level), 32'd1);
    tick();
    check("lat_t2_valid", 32'(m_valid), 32'd0);
    tick();
    check("lat_t3_valid", 32'(m_valid), 32'd1);
    check("lat_t3_data", 32'(m_data), 32'hA5);
    tick();
    check("lat_t4_level", 32'(level), 32'd0);
    check("lat_t4_valid", 32'(m_valid), 32'd0);

    // Reset mid-stream with five words stored.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    check("mid_level5", 32'(level), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rel_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    repeat (6) tick();
    check("mid_idle_valid", 32'(m_valid), 32'd0);
    check("mid_idle_level", 32'(level), 32'd0);

    // Full and pointer wrap.
    m_ready = 1'b0; s_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      s_data = 8'(8'h40 + i);
      tick();
    end
    s_valid = 1'b0;
    check("full_accepted", 32'(n_acc), 32'd19);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_level", 32'(level), 32'd19);
    for (int k = 0; k < 400 && sb.size() != 0; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("full_drained", 32'(sb.size()), 32'd0);
    check("full_level0", 32'(level), 32'd0);

    // Streaming at full rate.
    n_acc = 0; n_pop = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    check("stream_acc", 32'(n_acc), 32'd1000);
    check("stream_pop", 32'(n_pop), 32'd997);
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Random backpressure on both sides.
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_level0", 32'(level), 32'd0);

    // Flush with a read in flight and a word presented.
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 8'h11; tick();
    s_data = 8'h22; tick();
    check("flush_pre_level", 32'(level), 32'd2);
    clr = 1'b1; s_data = 8'h77;
    #1;
    check("flush_s_ready", 32'(s_ready), 32'd0);
    check("flush_ram_we", 32'(ram_we), 32'd0);
    tick();
    clr = 1'b0; s_valid = 1'b0;
    sb.delete();
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(m_valid), 32'd0);
    repeat (3) tick();
    check("flush_stale", 32'(m_valid), 32'd0);
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1; n_pop = 0;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 10 && n_pop == 0; k++) tick();
    check("flush_first_out", 32'(n_pop), 32'd1);
    check("flush_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
